// File: rtl/neuron_mac_sequencer.sv
// neuron_mac_sequencer
//   Evaluates one neuron on a single shared fixed-point multiply-accumulate
//   unit. Walks the enabled dendrite/weight pairs one per cycle, then adds the
//   bias weight (index N_INPUTS, with an implied input of 1.0). After that it
//   applies a step threshold and presents the weighted sum and the axon bit.
//   Sits between the dendrite/weight storage (synchronous-read RAMs) and the
//   layer controller.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        evaluation request, sampled only in IDLE
//   n_enabled    per-dendrite enable mask, latched on an accepted start
//   busy         evaluation in progress (ISSUE/DRAIN)
//   done         one-cycle pulse, sum_out/axon_out valid
//   rd_en        read strobe to the dendrite and weight RAMs
//   rd_addr      read index; N_INPUTS selects the bias weight
//   rd_dendrite  dendrite data, valid the cycle after rd_en
//   rd_weight    weight data, valid the cycle after rd_en
//   sum_out      saturated weighted sum including bias (Q.2*FRAC)
//   axon_out     1 when sum_out >= THRESH
module neuron_mac_sequencer #(
  parameter int unsigned N_INPUTS = 32,
  parameter int unsigned DW       = 16,
  parameter int unsigned FRAC     = 8,
  parameter int unsigned ACCW     = 40,
  parameter logic signed [ACCW-1:0] THRESH = '0,
  localparam int unsigned AW = $clog2(N_INPUTS + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [N_INPUTS-1:0]    n_enabled,
  output logic                   busy,
  output logic                   done,
  output logic                   rd_en,
  output logic [AW-1:0]          rd_addr,
  input  logic signed [DW-1:0]   rd_dendrite,
  input  logic signed [DW-1:0]   rd_weight,
  output logic signed [ACCW-1:0] sum_out,
  output logic                   axon_out
);

  // Working width: wide enough for any single term plus the accumulator,
  // with headroom so the sum itself cannot wrap before it is clamped.
  localparam int unsigned SW = ((ACCW > 2 * DW) ? ACCW : 2 * DW) + 2;
  localparam logic signed [SW-1:0] ACC_MAX = (SW'(1) <<< (ACCW - 1)) - SW'(1);
  localparam logic signed [SW-1:0] ACC_MIN = -ACC_MAX - SW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    FIRE  = 2'd3
  } state_t;

  state_t                 state_q;
  logic [N_INPUTS-1:0]    rem_mask_q;
  logic signed [ACCW-1:0] acc_q;
  logic signed [ACCW-1:0] acc_nxt;
  logic                   valid_q;
  logic                   bias_q;
  logic [AW-1:0]          low_idx;
  logic signed [2*DW-1:0] prod;
  logic signed [SW-1:0]   term;
  logic signed [SW-1:0]   sum_wide;

  // Lowest set bit of the remaining mask; defaults to the bias index.
  always_comb begin
    low_idx = AW'(N_INPUTS);
    for (int unsigned i = N_INPUTS; i > 0; i--) begin
      if (rem_mask_q[i-1]) low_idx = AW'(i - 1);
    end
  end

  assign rd_en   = (state_q == ISSUE);
  assign rd_addr = (state_q == ISSUE) ? low_idx : '0;
  assign busy    = (state_q == ISSUE) || (state_q == DRAIN);
  assign done    = (state_q == FIRE);

  // One MAC term per returned read; bias uses an implied input of 1.0.
  always_comb begin
    prod     = rd_dendrite * rd_weight;
    term     = bias_q ? (SW'(rd_weight) <<< FRAC) : SW'(prod);
    sum_wide = SW'(acc_q) + term;
    acc_nxt  = acc_q;
    if (valid_q) begin
      if (sum_wide > ACC_MAX)      acc_nxt = ACC_MAX[ACCW-1:0];
      else if (sum_wide < ACC_MIN) acc_nxt = ACC_MIN[ACCW-1:0];
      else                         acc_nxt = sum_wide[ACCW-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rem_mask_q <= '0;
      acc_q      <= '0;
      valid_q    <= 1'b0;
      bias_q     <= 1'b0;
      sum_out    <= '0;
      axon_out   <= 1'b0;
    end else begin
      valid_q <= rd_en;
      bias_q  <= rd_en && (rem_mask_q == '0);
      acc_q   <= ((state_q == IDLE) && start) ? '0 : acc_nxt;
      case (state_q)
        IDLE: begin
          if (start) begin
            rem_mask_q <= n_enabled;
            state_q    <= ISSUE;
          end
        end
        ISSUE: begin
          if (rem_mask_q != '0) rem_mask_q <= rem_mask_q & (rem_mask_q - N_INPUTS'(1));
          else                  state_q    <= DRAIN;
        end
        DRAIN: begin
          // The bias term lands on this edge; registering the result here
          // (from acc_nxt) makes sum_out/axon_out valid while done is high.
          sum_out  <= acc_nxt;
          axon_out <= (acc_nxt >= THRESH);
          state_q  <= FIRE;
        end
        FIRE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
